// File: rtl/ch_reset_sequencer.sv
// Staged per-channel active-low reset release after peripheral reset, followed by
// timed per-channel software reset pulses with a one-cycle acknowledge.
module ch_reset_sequencer #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned SW_RST_CYCLES = 32,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              slowest_sync_clk,
  input  logic              peripheral_reset,
  input  logic [NUM_CH-1:0] sw_rst_req,
  output logic [NUM_CH-1:0] sw_rst_ack,
  output logic [NUM_CH-1:0] ch_aresetn,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              seq_done
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_STAGE,
    S_RUN,
    S_SWRST
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  sel;
  logic [NUM_CH-1:0] pending;
  logic [IDX_W-1:0]  low_idx;
  logic [NUM_CH-1:0] clr_mask;

  // Fixed priority: scanning downward leaves the lowest set index selected.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (pending[i-1]) low_idx = IDX_W'(i - 1);
    end
  end

  always_comb begin
    clr_mask      = '0;
    clr_mask[sel] = 1'b1;
  end

  always_ff @(posedge slowest_sync_clk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state      <= S_STAGE;
      cnt        <= '0;
      idx        <= '0;
      sel        <= '0;
      pending    <= '0;
      ch_aresetn <= '0;
      sw_rst_ack <= '0;
      seq_done   <= 1'b0;
    end else begin
      sw_rst_ack <= '0;
      pending    <= pending | sw_rst_req;
      case (state)
        S_STAGE: begin
          if (cnt == GAP_LAST) begin
            ch_aresetn[idx] <= 1'b1;
            cnt             <= '0;
            if (idx == LAST_CH) begin
              seq_done <= 1'b1;
              state    <= S_RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (|pending) begin
            ch_aresetn[low_idx] <= 1'b0;
            sel                 <= low_idx;
            cnt                 <= '0;
            state               <= S_SWRST;
          end
        end
        S_SWRST: begin
          if (cnt == SW_LAST) begin
            ch_aresetn[sel] <= 1'b1;
            sw_rst_ack[sel] <= 1'b1;
            // A request arriving on the completion edge re-arms the channel.
            pending         <= (pending & ~clr_mask) | sw_rst_req;
            cnt             <= '0;
            state           <= S_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_STAGE;
      endcase
    end
  end

  assign ch_reset = ~ch_aresetn;

endmodule

// File: tb/tb_ch_reset_sequencer.sv
// Directed bench for ch_reset_sequencer with NUM_CH=4, GAP=16, SW_RST=32.
module tb_ch_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic [3:0] aresetn;
  logic [3:0] chrst;
  logic       done;

  int errors = 0;
  int checks = 0;

  ch_reset_sequencer #(
    .NUM_CH(4),
    .GAP_CYCLES(16),
    .SW_RST_CYCLES(32),
    .CNT_W(8)
  ) dut (
    .slowest_sync_clk(clk),
    .peripheral_reset(rst),
    .sw_rst_req(req),
    .sw_rst_ack(ack),
    .ch_aresetn(aresetn),
    .ch_reset(chrst),
    .seq_done(done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_n, input logic [3:0] exp_ack,
                         input logic exp_done);
    chk({tag, ".aresetn"}, {28'd0, aresetn}, {28'd0, exp_n});
    chk({tag, ".ch_reset"}, {28'd0, chrst}, {28'd0, ~exp_n});
    chk({tag, ".ack"}, {28'd0, ack}, {28'd0, exp_ack});
    chk({tag, ".seq_done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  initial begin
    logic [3:0] ack_seen;

    #2;
    chk_out("reset", 4'b0000, 4'b0000, 1'b0);
    tick(2);
    chk_out("reset_held", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;

    // Power-on staging; ch0 request sampled at edge 5 is held until S_RUN.
    tick(4);
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    tick(10);
    chk_out("e15", 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_out("e16", 4'b0001, 4'b0000, 1'b0);
    tick(16);
    chk_out("e32", 4'b0011, 4'b0000, 1'b0);
    tick(15);
    chk_out("e47", 4'b0011, 4'b0000, 1'b0);
    tick(1);
    chk_out("e48", 4'b0111, 4'b0000, 1'b0);
    tick(15);
    chk_out("e63", 4'b0111, 4'b0000, 1'b0);
    tick(1);
    chk_out("e64", 4'b1111, 4'b0000, 1'b1);
    tick(1);
    chk_out("e65_ch0_drop", 4'b1110, 4'b0000, 1'b1);
    tick(31);
    chk_out("e96_ch0_held", 4'b1110, 4'b0000, 1'b1);
    tick(1);
    chk_out("e97_ch0_ack", 4'b1111, 4'b0001, 1'b1);
    tick(1);
    chk_out("e98_idle", 4'b1111, 4'b0000, 1'b1);

    // Single request on ch2.
    req = 4'b0100;
    tick(1);
    req = 4'b0000;
    chk_out("ch2_pend", 4'b1111, 4'b0000, 1'b1);
    tick(1);
    chk_out("ch2_drop", 4'b1011, 4'b0000, 1'b1);
    tick(31);
    chk_out("ch2_held", 4'b1011, 4'b0000, 1'b1);
    tick(1);
    chk_out("ch2_ack", 4'b1111, 4'b0100, 1'b1);
    tick(1);
    chk_out("ch2_ack_end", 4'b1111, 4'b0000, 1'b1);

    // Re-request ch2 during its ack cycle: second ack 34 edges after the first.
    req = 4'b0100;
    tick(1);
    req = 4'b0000;
    tick(1);
    chk_out("rep_drop1", 4'b1011, 4'b0000, 1'b1);
    tick(32);
    chk_out("rep_ack1", 4'b1111, 4'b0100, 1'b1);
    req = 4'b0100;
    tick(1);
    req = 4'b0000;
    chk_out("rep_gap", 4'b1111, 4'b0000, 1'b1);
    tick(1);
    chk_out("rep_drop2", 4'b1011, 4'b0000, 1'b1);
    tick(31);
    chk_out("rep_held2", 4'b1011, 4'b0000, 1'b1);
    tick(1);
    chk_out("rep_ack2", 4'b1111, 4'b0100, 1'b1);
    tick(1);

    // Simultaneous ch1+ch3: ch1 first, one idle cycle, then ch3.
    req = 4'b1010;
    tick(1);
    req = 4'b0000;
    tick(1);
    chk_out("sim_ch1_drop", 4'b1101, 4'b0000, 1'b1);
    tick(31);
    chk_out("sim_ch1_held", 4'b1101, 4'b0000, 1'b1);
    tick(1);
    chk_out("sim_ch1_ack", 4'b1111, 4'b0010, 1'b1);
    tick(1);
    chk_out("sim_ch3_drop", 4'b0111, 4'b0000, 1'b1);
    tick(31);
    chk_out("sim_ch3_held", 4'b0111, 4'b0000, 1'b1);
    tick(1);
    chk_out("sim_ch3_ack", 4'b1111, 4'b1000, 1'b1);
    tick(1);
    chk_out("sim_idle", 4'b1111, 4'b0000, 1'b1);

    // Reset 10 cycles into a ch1 pulse with ch3 pending.
    req = 4'b1010;
    tick(1);
    req = 4'b0000;
    tick(1);
    chk_out("mid_ch1_drop", 4'b1101, 4'b0000, 1'b1);
    tick(10);
    rst = 1'b1;
    #1;
    chk_out("mid_reset", 4'b0000, 4'b0000, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(15);
    chk_out("re_e15", 4'b0000, 4'b0000, 1'b0);
    tick(1);
    chk_out("re_e16", 4'b0001, 4'b0000, 1'b0);
    tick(48);
    chk_out("re_e64", 4'b1111, 4'b0000, 1'b1);
    ack_seen = '0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      ack_seen = ack_seen | ack | ~aresetn;
    end
    chk("re_no_service", {28'd0, ack_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
